// File: rtl/hm_mem_pkg.sv
// Shared definitions for the hm dual-port memory: read-mode encodings and the
// byte-lane merge used by both the write path and write-first reads.
package hm_mem_pkg;

  localparam int RM_READ_FIRST  = 0;
  localparam int RM_WRITE_FIRST = 1;

  // Widest word the merge helper handles; callers size-cast in and out.
  localparam int MAX_DW = 512;
  localparam int MAX_NB = MAX_DW / 8;

  typedef logic [MAX_DW-1:0] word_t;
  typedef logic [MAX_NB-1:0] mask_t;

  function automatic word_t lane_merge(input word_t old_w, input word_t new_w, input mask_t mask);
    word_t res;
    res = old_w;
    for (int i = 0; i < MAX_NB; i++) begin
      if (mask[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/hm_mem_outreg.sv
// Per-port read pipeline: STAGES flops of data/valid. Data in each stage only
// advances alongside a valid bit, so the output holds between accesses.
module hm_mem_outreg #(
  parameter int DATA_WIDTH = 32,
  parameter int STAGES     = 1
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  in_vld,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_vld,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic [STAGES-1:0]                 vld_d, vld_q;
  logic [STAGES-1:0][DATA_WIDTH-1:0] dat_d, dat_q;
  logic [STAGES:0]                   vld_pipe;
  logic [STAGES:0][DATA_WIDTH-1:0]   dat_pipe;

  assign vld_pipe = {vld_q, in_vld};
  assign dat_pipe = {dat_q, in_data};

  always_comb begin
    vld_d = '0;
    dat_d = dat_q;
    for (int s = 0; s < STAGES; s++) begin
      vld_d[s] = vld_pipe[s];
      if (vld_pipe[s]) dat_d[s] = dat_pipe[s];
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign out_vld  = vld_q[STAGES-1];
  assign out_data = dat_q[STAGES-1];

endmodule

// File: rtl/hm_memory_dp.sv
// True dual-port byte-writable RAM with deterministic same-address collision
// handling (A wins shared lanes), read-valid strobes and a collision counter.
module hm_memory_dp
  import hm_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int READ_MODE  = RM_READ_FIRST,
  parameter int OUT_REG    = 0,
  parameter int CNT_WIDTH  = 16,
  localparam int NB        = DATA_WIDTH / 8
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  a_en,
  input  logic [NB-1:0]         a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_di,
  output logic [DATA_WIDTH-1:0] a_do,
  output logic                  a_valid,
  input  logic                  b_en,
  input  logic [NB-1:0]         b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_di,
  output logic [DATA_WIDTH-1:0] b_do,
  output logic                  b_valid,
  output logic                  coll,
  output logic [CNT_WIDTH-1:0]  coll_cnt
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

  logic                  a_acc, b_acc, same_addr, any_wr;
  logic [NB-1:0]         a_msk, b_msk;
  logic [DATA_WIDTH-1:0] a_old, b_old, a_new, b_new, ab_new, a_rd, b_rd;
  logic                  coll_d, coll_q;
  logic [CNT_WIDTH-1:0]  cnt_d, cnt_q;

  always_comb begin
    // Accesses presented during reset are dropped entirely.
    a_acc     = a_en & ~sys_rst;
    b_acc     = b_en & ~sys_rst;
    a_msk     = a_acc ? a_we : '0;
    b_msk     = b_acc ? b_we : '0;
    a_old     = mem_q[a_addr];
    b_old     = mem_q[b_addr];
    same_addr = (a_addr == b_addr);
    any_wr    = (|a_msk) | (|b_msk);
    a_new     = DATA_WIDTH'(lane_merge(word_t'(a_old), word_t'(a_di), mask_t'(a_msk)));
    b_new     = DATA_WIDTH'(lane_merge(word_t'(b_old), word_t'(b_di), mask_t'(b_msk)));
    // A is layered over B so A owns any lane both ports write.
    ab_new    = DATA_WIDTH'(lane_merge(word_t'(b_new), word_t'(a_di), mask_t'(a_msk)));
    a_rd      = (READ_MODE == RM_WRITE_FIRST) ? a_new : a_old;
    b_rd      = (READ_MODE == RM_WRITE_FIRST) ? b_new : b_old;
    coll_d    = a_acc & b_acc & same_addr;
    cnt_d     = cnt_q;
    if (coll_q && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge sys_clk) begin
    if (same_addr && any_wr) begin
      mem_q[a_addr] <= ab_new;
    end else begin
      if (|a_msk) mem_q[a_addr] <= a_new;
      if (|b_msk) mem_q[b_addr] <= b_new;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      coll_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      coll_q <= coll_d;
      cnt_q  <= cnt_d;
    end
  end

  assign coll     = coll_q;
  assign coll_cnt = cnt_q;

  hm_mem_outreg #(.DATA_WIDTH(DATA_WIDTH), .STAGES(1 + OUT_REG)) u_a_out (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .in_vld   (a_acc),
    .in_data  (a_rd),
    .out_vld  (a_valid),
    .out_data (a_do)
  );

  hm_mem_outreg #(.DATA_WIDTH(DATA_WIDTH), .STAGES(1 + OUT_REG)) u_b_out (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .in_vld   (b_acc),
    .in_data  (b_rd),
    .out_vld  (b_valid),
    .out_data (b_do)
  );

endmodule

// File: tb/tb_hm_memory_dp.sv
// Scoreboard bench: two DUTs (read-first/L=1/16-bit count and
// write-first/L=2/4-bit count) share stimulus; a word-array model predicts reads.
module tb_hm_memory_dp;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int NB = DW / 8;
  localparam int CMAX [2] = '{65535, 15};

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          a_en = 1'b0, b_en = 1'b0;
  logic [NB-1:0] a_we = '0, b_we = '0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_di = '0, b_di = '0;

  logic [1:0][DW-1:0] a_do, b_do;
  logic [1:0]         a_valid, b_valid, coll;
  logic [15:0]        cnt0;
  logic [3:0]         cnt1;

  hm_memory_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_MODE(0), .OUT_REG(0), .CNT_WIDTH(16)) dut0 (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_di(a_di), .a_do(a_do[0]), .a_valid(a_valid[0]),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_di(b_di), .b_do(b_do[0]), .b_valid(b_valid[0]),
    .coll(coll[0]), .coll_cnt(cnt0)
  );

  hm_memory_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_MODE(1), .OUT_REG(1), .CNT_WIDTH(4)) dut1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_di(a_di), .a_do(a_do[1]), .a_valid(a_valid[1]),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_di(b_di), .b_do(b_do[1]), .b_valid(b_valid[1]),
    .coll(coll[1]), .coll_cnt(cnt1)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct { int due; logic rst; logic [DW-1:0] data; } rd_t;
  typedef struct { int due; logic coll; int cnt; } cl_t;

  rd_t           rq [4][$];   // index dut*2 + port
  cl_t           cq [2][$];
  logic [DW-1:0] last_do [4] = '{default: '0};
  logic [DW-1:0] mem_m [1 << AW];
  int            cnt_m [2] = '{0, 0};
  int            total = 0;
  int            bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  // One bus cycle of stimulus plus the model's prediction for it.
  task automatic step(input logic rst,
                      input logic ae, input logic [NB-1:0] awe, input logic [AW-1:0] aad, input logic [DW-1:0] adi,
                      input logic be, input logic [NB-1:0] bwe, input logic [AW-1:0] bad_, input logic [DW-1:0] bdi);
    int n;
    logic c;
    logic [DW-1:0] old_a, old_b, new_a, new_b;
    @(posedge sys_clk);
    #1;
    sys_rst = rst;
    a_en = ae; a_we = awe; a_addr = aad; a_di = adi;
    b_en = be; b_we = bwe; b_addr = bad_; b_di = bdi;
    n = cyc;
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        while (rq[k].size() > 0 && rq[k][$].due > n) void'(rq[k].pop_back());
        rq[k].push_back('{n + 1, 1'b1, '0});
      end
      for (int d = 0; d < 2; d++) begin
        cq[d].push_back('{n + 1, 1'b0, 0});
        cnt_m[d] = 0;
      end
    end else begin
      old_a = mem_m[aad];
      old_b = mem_m[bad_];
      new_a = old_a;
      new_b = old_b;
      for (int i = 0; i < NB; i++) begin
        if (awe[i]) new_a[8*i +: 8] = adi[8*i +: 8];
        if (bwe[i]) new_b[8*i +: 8] = bdi[8*i +: 8];
      end
      for (int d = 0; d < 2; d++) begin
        if (ae) rq[2*d].push_back('{n + 1 + d, 1'b0, (d == 1) ? new_a : old_a});
        if (be) rq[2*d+1].push_back('{n + 1 + d, 1'b0, (d == 1) ? new_b : old_b});
      end
      c = ae && be && (aad == bad_);
      for (int d = 0; d < 2; d++) begin
        cq[d].push_back('{n + 1, c, cnt_m[d]});
        if (c && cnt_m[d] < CMAX[d]) cnt_m[d]++;
      end
      // B first, then A's lanes on top: A wins shared lanes at one address.
      if (be) mem_m[bad_] = new_b;
      if (ae) for (int i = 0; i < NB; i++) if (awe[i]) mem_m[aad][8*i +: 8] = adi[8*i +: 8];
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
  endtask

  always @(negedge sys_clk) begin
    rd_t           e;
    cl_t           ce;
    logic          v, ev;
    logic [DW-1:0] dd, ed;
    logic [15:0]   ca;
    if (cyc > 0) begin
      for (int k = 0; k < 4; k++) begin
        v  = (k % 2 == 1) ? b_valid[k/2] : a_valid[k/2];
        dd = (k % 2 == 1) ? b_do[k/2] : a_do[k/2];
        if (rq[k].size() > 0 && rq[k][0].due == cyc) begin
          e = rq[k].pop_front();
          ev = ~e.rst;
          ed = e.data;
          last_do[k] = ed;
        end else begin
          ev = 1'b0;
          ed = last_do[k];
        end
        check($sformatf("rd_dut%0d_%s", k / 2, (k % 2 == 1) ? "b" : "a"), 64'({v, dd}), 64'({ev, ed}));
      end
      for (int d = 0; d < 2; d++) begin
        if (cq[d].size() > 0 && cq[d][0].due == cyc) begin
          ce = cq[d].pop_front();
          ca = (d == 1) ? {12'b0, cnt1} : cnt0;
          check($sformatf("coll_dut%0d", d), 64'(coll[d]), 64'(ce.coll));
          check($sformatf("cnt_dut%0d", d), 64'(ca), 64'(ce.cnt));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem_m[i] = '0;
    repeat (3) step(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, '0, '0);

    // Basic write then cross-port read
    step(1'b0, 1'b1, 4'hF, 10'd5, 32'hDEADBEEF, 1'b0, 4'h0, 10'd0, 32'h0);
    step(1'b0, 1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 4'h0, 10'd5, 32'h0);
    // Byte lanes
    step(1'b0, 1'b1, 4'hF, 10'd7, 32'h11223344, 1'b0, 4'h0, 10'd0, 32'h0);
    step(1'b0, 1'b1, 4'b0101, 10'd7, 32'hAABBCCDD, 1'b0, 4'h0, 10'd0, 32'h0);
    step(1'b0, 1'b1, 4'h0, 10'd7, 32'h0, 1'b0, 4'h0, 10'd0, 32'h0);
    // Write enables ignored without enable
    step(1'b0, 1'b0, 4'hF, 10'd7, 32'hFFFFFFFF, 1'b0, 4'hF, 10'd7, 32'hFFFFFFFF);
    step(1'b0, 1'b1, 4'h0, 10'd7, 32'h0, 1'b0, 4'h0, 10'd0, 32'h0);
    // Write/write collision
    step(1'b0, 1'b1, 4'hF, 10'd3, 32'h0, 1'b0, 4'h0, 10'd0, 32'h0);
    step(1'b0, 1'b1, 4'b0011, 10'd3, 32'h000000AA, 1'b1, 4'b0110, 10'd3, 32'hBBBBBBBB);
    step(1'b0, 1'b1, 4'h0, 10'd3, 32'h0, 1'b0, 4'h0, 10'd0, 32'h0);
    // Read modes with cross-port reader
    step(1'b0, 1'b1, 4'hF, 10'd9, 32'h1, 1'b0, 4'h0, 10'd0, 32'h0);
    step(1'b0, 1'b1, 4'hF, 10'd9, 32'h2, 1'b1, 4'h0, 10'd9, 32'h0);
    // Reset while a read is in flight
    step(1'b0, 1'b1, 4'h0, 10'd9, 32'h0, 1'b0, 4'h0, 10'd0, 32'h0);
    step(1'b1, 1'b1, 4'hF, 10'd9, 32'h55, 1'b0, 4'h0, 10'd0, 32'h0);
    step(1'b0, 1'b1, 4'h0, 10'd9, 32'h0, 1'b0, 4'h0, 10'd0, 32'h0);
    idle();
    idle();
    // Counter saturation (4-bit counter on dut1)
    repeat (20) step(1'b0, 1'b1, 4'h0, 10'd1, 32'h0, 1'b1, 4'h0, 10'd1, 32'h0);
    idle();
    idle();

    for (int t = 0; t < 2000; t++) begin
      logic [AW-1:0] aa, ba;
      aa = ($urandom_range(0, 3) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      ba = ($urandom_range(0, 3) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 3) != 0), NB'($urandom), aa, $urandom,
           ($urandom_range(0, 3) != 0), NB'($urandom), ba, $urandom);
    end

    repeat (4) idle();
    @(negedge sys_clk);
    #1;
    for (int k = 0; k < 4; k++) check($sformatf("drain_rd%0d", k), 64'(rq[k].size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
